// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions for the host bridge: opcodes, word size and
// the per-source bookkeeping record kept by the source table.
package tl_ul_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL_DATA    = 3'd0,
    A_PUT_PARTIAL_DATA = 3'd1,
    A_GET              = 3'd4
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1
  } d_opcode_e;

  localparam int TL_WORD_SIZE = 2;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        expect_data;
    logic        error;
    logic [31:0] data;
  } slot_t;

  // A full-word write is the only one that may use PutFullData.
  function automatic a_opcode_e a_opcode_for(input logic write, input logic [3:0] mask);
    if (!write)           return A_GET;
    else if (mask == 4'hF) return A_PUT_FULL_DATA;
    else                  return A_PUT_PARTIAL_DATA;
  endfunction

endpackage

// File: rtl/tl_ul_host_bridge_tl_source_table.sv
// In-flight transaction table: slots are allocated and retired in order, while
// D-channel beats may complete them in any order by source ID.
module tl_source_table
  import tl_ul_pkg::*;
#(
  parameter int TL_RS           = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PW             = $clog2(MAX_OUTSTANDING),
  localparam int CW             = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc,
  input  logic             alloc_write,
  input  logic             d_valid,
  input  logic [TL_RS-1:0] d_source,
  input  logic [2:0]       d_opcode,
  input  logic             d_fault,
  input  logic [31:0]      d_data,
  input  logic             retire,
  output logic [PW-1:0]    alloc_ptr,
  output logic [CW-1:0]    count,
  output logic             head_done,
  output logic [31:0]      head_data,
  output logic             head_error,
  output logic             unexpected
);

  slot_t         slots [MAX_OUTSTANDING];
  logic [PW-1:0] retire_ptr;
  logic [PW-1:0] d_idx;
  logic          d_in_range;
  logic          d_hit;
  d_opcode_e     d_expected;

  assign d_idx      = d_source[PW-1:0];
  assign d_in_range = {1'b0, d_source} < (TL_RS + 1)'(MAX_OUTSTANDING);
  assign d_hit      = d_valid && d_in_range && slots[d_idx].busy && !slots[d_idx].done;
  assign d_expected = slots[d_idx].expect_data ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
  assign unexpected = d_valid && !d_hit;

  assign head_done  = slots[retire_ptr].done;
  assign head_error = slots[retire_ptr].error;
  assign head_data  = slots[retire_ptr].expect_data ? slots[retire_ptr].data : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is reset as a whole because busy/done must start clear
      // and a late D beat after reset has to see every slot as free.
      for (int i = 0; i < MAX_OUTSTANDING; i++) slots[i] <= '0;
      alloc_ptr  <= '0;
      retire_ptr <= '0;
      count      <= '0;
    end else begin
      // Alloc, capture and retire always target distinct slots: alloc only
      // hits a free slot, capture a busy-not-done one, retire a done one.
      if (alloc) begin
        slots[alloc_ptr] <= '{busy: 1'b1, done: 1'b0, expect_data: !alloc_write,
                              error: 1'b0, data: 32'h0};
        alloc_ptr        <= alloc_ptr + PW'(1);
      end
      if (d_hit) begin
        slots[d_idx].done  <= 1'b1;
        slots[d_idx].data  <= d_data;
        slots[d_idx].error <= d_fault || (d_opcode != d_expected);
      end
      if (retire) begin
        slots[retire_ptr].busy <= 1'b0;
        slots[retire_ptr].done <= 1'b0;
        retire_ptr             <= retire_ptr + PW'(1);
      end
      case ({alloc, retire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tl_ul_host_bridge.sv
// TL-UL host bridge: registered A-channel issue stage in front of an in-order
// response table that tolerates out-of-order D-channel completion.
module tl_ul_host_bridge
  import tl_ul_pkg::*;
#(
  parameter int TL_RS           = 4,
  parameter int TL_SZ           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic             tlh_clock_i,
  input  logic             tlh_reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [31:0]      req_addr_i,
  input  logic [31:0]      req_wdata_i,
  input  logic [3:0]       req_mask_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [31:0]      resp_rdata_o,
  output logic             resp_error_o,
  output logic [2:0]       tl_a_opcode_o,
  output logic [2:0]       tl_a_param_o,
  output logic [TL_SZ-1:0] tl_a_size_o,
  output logic [TL_RS-1:0] tl_a_source_o,
  output logic [31:0]      tl_a_address_o,
  output logic [3:0]       tl_a_mask_o,
  output logic [31:0]      tl_a_data_o,
  output logic             tl_a_corrupt_o,
  output logic             tl_a_valid_o,
  input  logic             tl_a_ready_i,
  input  logic [2:0]       tl_d_opcode_i,
  input  logic [1:0]       tl_d_param_i,
  input  logic [TL_SZ-1:0] tl_d_size_i,
  input  logic [TL_RS-1:0] tl_d_source_i,
  input  logic             tl_d_denied_i,
  input  logic [31:0]      tl_d_data_i,
  input  logic             tl_d_corrupt_i,
  input  logic             tl_d_valid_i,
  output logic             tl_d_ready_o,
  output logic             unexpected_d_o
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  logic [PW-1:0] alloc_ptr;
  logic [CW-1:0] count;
  logic          a_stage_free;
  logic          accept;
  logic          retire;
  logic          unexpected;
  logic          unused_inputs;

  assign unused_inputs = ^{tl_d_param_i, tl_d_size_i, req_addr_i[1:0]};

  assign a_stage_free = !tl_a_valid_o || tl_a_ready_i;
  assign req_ready_o  = (count < CW'(MAX_OUTSTANDING)) && a_stage_free;
  assign accept       = req_valid_i && req_ready_o;
  assign retire       = resp_valid_o && resp_ready_i;

  assign tl_a_param_o   = 3'd0;
  assign tl_a_corrupt_o = 1'b0;
  assign tl_d_ready_o   = 1'b1;

  always_ff @(posedge tlh_clock_i or negedge tlh_reset_ni) begin
    if (!tlh_reset_ni) begin
      tl_a_valid_o   <= 1'b0;
      tl_a_opcode_o  <= '0;
      tl_a_size_o    <= '0;
      tl_a_source_o  <= '0;
      tl_a_address_o <= '0;
      tl_a_mask_o    <= '0;
      tl_a_data_o    <= '0;
      unexpected_d_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; accept itself already depends on tl_a_valid_o.
      if (accept) begin
        tl_a_valid_o   <= 1'b1;
        tl_a_opcode_o  <= a_opcode_for(req_write_i, req_mask_i);
        tl_a_size_o    <= TL_SZ'(TL_WORD_SIZE);
        tl_a_source_o  <= TL_RS'(alloc_ptr);
        tl_a_address_o <= {req_addr_i[31:2], 2'b00};
        tl_a_mask_o    <= req_write_i ? req_mask_i : 4'hF;
        tl_a_data_o    <= req_write_i ? req_wdata_i : 32'h0;
      end else if (tl_a_ready_i) begin
        tl_a_valid_o   <= 1'b0;
      end
      if (unexpected) unexpected_d_o <= 1'b1;
    end
  end

  tl_source_table #(
    .TL_RS           (TL_RS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_source_table (
    .clk         (tlh_clock_i),
    .rst_n       (tlh_reset_ni),
    .alloc       (accept),
    .alloc_write (req_write_i),
    .d_valid     (tl_d_valid_i),
    .d_source    (tl_d_source_i),
    .d_opcode    (tl_d_opcode_i),
    .d_fault     (tl_d_denied_i || tl_d_corrupt_i),
    .d_data      (tl_d_data_i),
    .retire      (retire),
    .alloc_ptr   (alloc_ptr),
    .count       (count),
    .head_done   (resp_valid_o),
    .head_data   (resp_rdata_o),
    .head_error  (resp_error_o),
    .unexpected  (unexpected)
  );

endmodule

// File: tb/tb_tl_ul_host_bridge.sv
// Directed bench for the TL-UL host bridge: expected host responses are queued
// at request accept and compared in order as the bridge returns them.
module tb_tl_ul_host_bridge;

  localparam int TL_RS = 4;
  localparam int TL_SZ = 4;
  localparam int MAX_OUTSTANDING = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_ready, req_write;
  logic [31:0]      req_addr, req_wdata;
  logic [3:0]       req_mask;
  logic             resp_valid, resp_ready, resp_error;
  logic [31:0]      resp_rdata;
  logic [2:0]       a_opcode, a_param;
  logic [TL_SZ-1:0] a_size;
  logic [TL_RS-1:0] a_source;
  logic [31:0]      a_address, a_data;
  logic [3:0]       a_mask;
  logic             a_corrupt, a_valid, a_ready;
  logic [2:0]       d_opcode;
  logic [1:0]       d_param;
  logic [TL_SZ-1:0] d_size;
  logic [TL_RS-1:0] d_source;
  logic             d_denied, d_corrupt, d_valid, d_ready;
  logic [31:0]      d_data;
  logic             unexpected_d;

  typedef struct {
    logic [31:0] rdata;
    logic        error;
  } resp_t;

  resp_t sb_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  tl_ul_host_bridge #(
    .TL_RS(TL_RS), .TL_SZ(TL_SZ), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .tlh_clock_i(clk),          .tlh_reset_ni(rst_n),
    .req_valid_i(req_valid),    .req_ready_o(req_ready),
    .req_write_i(req_write),    .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),    .req_mask_i(req_mask),
    .resp_valid_o(resp_valid),  .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata),  .resp_error_o(resp_error),
    .tl_a_opcode_o(a_opcode),   .tl_a_param_o(a_param),
    .tl_a_size_o(a_size),       .tl_a_source_o(a_source),
    .tl_a_address_o(a_address), .tl_a_mask_o(a_mask),
    .tl_a_data_o(a_data),       .tl_a_corrupt_o(a_corrupt),
    .tl_a_valid_o(a_valid),     .tl_a_ready_i(a_ready),
    .tl_d_opcode_i(d_opcode),   .tl_d_param_i(d_param),
    .tl_d_size_i(d_size),       .tl_d_source_i(d_source),
    .tl_d_denied_i(d_denied),   .tl_d_data_i(d_data),
    .tl_d_corrupt_i(d_corrupt), .tl_d_valid_i(d_valid),
    .tl_d_ready_o(d_ready),     .unexpected_d_o(unexpected_d)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one host request until accepted, queues its expected response and
  // checks the A beat that appears one cycle later.
  task automatic send_req(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, input logic [31:0] exp_rdata,
                          input logic exp_err, input logic [3:0] exp_src);
    bit accepted = 1'b0;
    logic [2:0] exp_op;
    req_valid = 1'b1;
    req_write = write;
    req_addr  = addr;
    req_wdata = wdata;
    req_mask  = mask;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      accepted = req_ready;
      tick();
    end
    req_valid = 1'b0;
    if (!accepted) begin
      check("req_accept_timeout", 32'd0, 32'd1);
    end else begin
      sb_q.push_back('{rdata: exp_rdata, error: exp_err});
      exp_op = !write ? 3'd4 : (mask == 4'hF ? 3'd0 : 3'd1);
      check("a_valid",   a_valid,   1);
      check("a_opcode",  a_opcode,  exp_op);
      check("a_source",  a_source,  exp_src);
      check("a_address", a_address, {addr[31:2], 2'b00});
      check("a_mask",    a_mask,    write ? mask : 4'hF);
      check("a_data",    a_data,    write ? wdata : 32'h0);
      check("a_size",    a_size,    2);
      check("a_param",   {a_corrupt, a_param}, 0);
    end
  endtask

  task automatic d_beat(input logic [3:0] src, input logic [2:0] op, input logic [31:0] data,
                        input logic denied, input logic corrupt);
    d_valid   = 1'b1;
    d_source  = src;
    d_opcode  = op;
    d_data    = data;
    d_denied  = denied;
    d_corrupt = corrupt;
    tick();
    d_valid   = 1'b0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
  endtask

  task automatic expect_resp(input string tag);
    bit seen = 1'b0;
    resp_t exp;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        if (sb_q.size() == 0) begin
          check({tag, "_sb_underflow"}, 32'd0, 32'd1);
        end else begin
          exp = sb_q.pop_front();
          check({tag, "_rdata"}, resp_rdata, exp.rdata);
          check({tag, "_error"}, resp_error, exp.error);
        end
        resp_ready = 1'b1;
      end
      tick();
      resp_ready = 1'b0;
    end
    if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_mask = '0;
    resp_ready = 1'b0; a_ready = 1'b1;
    d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = 4'd2; d_source = '0;
    d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0;

    // Reset state
    #12;
    check("rst_a_valid",    a_valid,      0);
    check("rst_resp_valid", resp_valid,   0);
    check("rst_unexpected", unexpected_d, 0);
    check("rst_a_address",  a_address,    0);
    check("rst_d_ready",    d_ready,      1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_req_ready", req_ready, 1);

    // Single read, answered three cycles later
    send_req(1'b0, 32'h1000_0003, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 4'd0);
    tick();
    check("a_drained", a_valid, 0);
    tick();
    check("resp_before_d", resp_valid, 0);
    d_beat(4'd0, 3'd1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("resp_latency", resp_valid, 1);
    expect_resp("rd0");

    // Partial, full and single-byte writes; returned D data must not leak out
    send_req(1'b1, 32'h2000_0004, 32'h1234_5678, 4'h3, 32'h0, 1'b0, 4'd1);
    d_beat(4'd1, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    expect_resp("wr_partial");
    send_req(1'b1, 32'h2000_0008, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 4'd2);
    d_beat(4'd2, 3'd0, 32'h0, 1'b0, 1'b0);
    expect_resp("wr_full");
    send_req(1'b1, 32'h2000_000C, 32'h0000_0011, 4'h8, 32'h0, 1'b0, 4'd3);
    d_beat(4'd3, 3'd0, 32'h0, 1'b0, 1'b0);
    expect_resp("wr_byte");

    // Four back-to-back reads after pointer wrap, answered out of order
    for (int s = 0; s < 4; s++)
      send_req(1'b0, 32'h4000_0000 + 32'(4 * s), 32'h0, 4'h0, 32'(s * 16), 1'b0, 4'(s));
    req_valid = 1'b1;
    req_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_req_ready", req_ready, 0);
      tick();
    end
    req_valid = 1'b0;
    d_beat(4'd3, 3'd1, 32'd48, 1'b0, 1'b0);
    d_beat(4'd1, 3'd1, 32'd16, 1'b0, 1'b0);
    d_beat(4'd0, 3'd1, 32'd0,  1'b0, 1'b0);
    d_beat(4'd2, 3'd1, 32'd32, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) expect_resp("ooo");

    // A-channel backpressure
    a_ready = 1'b0;
    send_req(1'b1, 32'h3000_0010, 32'hAAAA_5555, 4'hF, 32'h0, 1'b0, 4'd0);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h3000_0020;
    req_wdata = 32'h0BAD_0BAD; req_mask = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_a_valid",   a_valid,   1);
      check("bp_a_data",    a_data,    32'hAAAA_5555);
      check("bp_a_address", a_address, 32'h3000_0010);
      tick();
    end
    req_valid = 1'b0;
    a_ready = 1'b1;
    tick();
    check("bp_release", a_valid, 0);
    d_beat(4'd0, 3'd0, 32'h0, 1'b0, 1'b0);
    expect_resp("bp_wr");

    // Error responses: denied write, opcode mismatch on read, corrupt read
    send_req(1'b1, 32'h5000_0000, 32'h1, 4'hF, 32'h0, 1'b1, 4'd1);
    d_beat(4'd1, 3'd0, 32'h0, 1'b1, 1'b0);
    expect_resp("denied");
    send_req(1'b0, 32'h5000_0004, 32'h0, 4'h0, 32'h0, 1'b1, 4'd2);
    d_beat(4'd2, 3'd0, 32'h0, 1'b0, 1'b0);
    expect_resp("op_mismatch");
    send_req(1'b0, 32'h5000_0008, 32'h0, 4'h0, 32'h99, 1'b1, 4'd3);
    d_beat(4'd3, 3'd1, 32'h99, 1'b0, 1'b1);
    expect_resp("corrupt");

    // Stray D beat while idle
    check("pre_unexpected", unexpected_d, 0);
    d_beat(4'd2, 3'd1, 32'h0, 1'b0, 1'b0);
    check("idle_unexpected", unexpected_d, 1);
    check("idle_no_resp",    resp_valid,   0);
    tick();
    check("unexpected_sticky", unexpected_d, 1);

    // Reset with two requests outstanding
    send_req(1'b0, 32'h6000_0000, 32'h0, 4'h0, 32'h0, 1'b0, 4'd0);
    send_req(1'b0, 32'h6000_0004, 32'h0, 4'h0, 32'h0, 1'b0, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_a_valid",    a_valid,      0);
    check("mid_rst_resp_valid", resp_valid,   0);
    check("mid_rst_unexpected", unexpected_d, 0);
    check("mid_rst_a_opcode",   a_opcode,     0);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    d_beat(4'd0, 3'd1, 32'h1234, 1'b0, 1'b0);
    check("late_d_unexpected", unexpected_d, 1);
    check("late_d_no_resp",    resp_valid,   0);

    // Out-of-range and already-done sources must not touch live slots
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send_req(1'b0, 32'h7000_0000, 32'h0, 4'h0, 32'hA0, 1'b0, 4'd0);
    send_req(1'b0, 32'h7000_0004, 32'h0, 4'h0, 32'hB1, 1'b0, 4'd1);
    check("pre_range_unexpected", unexpected_d, 0);
    d_beat(4'd5, 3'd1, 32'h55, 1'b0, 1'b0);
    check("range_unexpected", unexpected_d, 1);
    d_beat(4'd0, 3'd1, 32'hA0, 1'b0, 1'b0);
    d_beat(4'd0, 3'd1, 32'hEE, 1'b0, 1'b0);
    d_beat(4'd1, 3'd1, 32'hB1, 1'b0, 1'b0);
    expect_resp("live0");
    expect_resp("live1");

    check("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tl_ul_host_bridge.md
Name: tl_ul_host_bridge

Overview:
- TileLink-UL initiator (master) bridge: converts a simple host request/response port into TL-UL A-channel Get/PutFullData/PutPartialData and accepts D-channel AccessAck/AccessAckData.
- Sits between CPU-side or DMA-side logic and TL-UL peripheral slaves (UART, timers, GPIO).
- Keeps up to MAX_OUTSTANDING transactions in flight, each with its own source ID.
- Returns host responses in request order, even when slaves respond out of order.

Parameters:
- TL_RS, 4, source ID width; must satisfy 2^TL_RS >= MAX_OUTSTANDING.
- TL_SZ, 4, size field width.
- MAX_OUTSTANDING, 4, number of in-flight slots; power of two, 2..16.

Ports:
- tlh_clock_i  in  1  single clock.
- tlh_reset_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  host request valid.
- req_ready_o  out  1  host request accepted when valid&ready.
- req_write_i  in  1  1=write, 0=read.
- req_addr_i  in  32  byte address; bits [1:0] ignored.
- req_wdata_i  in  32  write data.
- req_mask_i  in  4  byte enables for writes.
- resp_valid_o  out  1  host response valid.
- resp_ready_i  in  1  host response consumed when valid&ready.
- resp_rdata_o  out  32  read data; 0 for writes.
- resp_error_o  out  1  denied, corrupt or opcode mismatch.
- tl_a_opcode_o  out  3;  tl_a_param_o  out  3;  tl_a_size_o  out  TL_SZ;  tl_a_source_o  out  TL_RS.
- tl_a_address_o  out  32;  tl_a_mask_o  out  4;  tl_a_data_o  out  32;  tl_a_corrupt_o  out  1.
- tl_a_valid_o  out  1;  tl_a_ready_i  in  1.
- tl_d_opcode_i  in  3;  tl_d_param_i  in  2;  tl_d_size_i  in  TL_SZ;  tl_d_source_i  in  TL_RS.
- tl_d_denied_i  in  1;  tl_d_data_i  in  32;  tl_d_corrupt_i  in  1.
- tl_d_valid_i  in  1;  tl_d_ready_o  out  1.
- unexpected_d_o  out  1  sticky: a D beat arrived for a source that was not outstanding.

Behaviour:
- Reset (async assert, sync deassert edge): tl_a_valid_o=0, resp_valid_o=0, unexpected_d_o=0. All slots are free with done=0. Alloc and retire pointers are 0, count is 0. All A payload registers are 0.
- A channel is fully registered.
  - req_ready_o = (count < MAX_OUTSTANDING) & (!tl_a_valid_o | tl_a_ready_i).
  - On accept, the A registers load on the next edge and tl_a_valid_o=1: one cycle request-to-A latency.
  - The A payload is held stable while tl_a_valid_o & !tl_a_ready_i.
- Opcode encoding:
  - Read -> Get (4).
  - Write with mask 4'hF -> PutFullData (0).
  - Any other write mask -> PutPartialData (1).
  - A read drives a_mask=4'hF and a_data=0.
- Fixed A fields: a_size=2, a_param=0, a_corrupt=0, a_address={req_addr_i[31:2],2'b00}, a_source=alloc pointer.
- Slot allocation at request accept:
  - slot[alloc] is marked busy and records expected response: AccessAckData(1) for reads, AccessAck(0) for writes.
  - alloc increments modulo MAX_OUTSTANDING.
- tl_d_ready_o is constant 1; the table always has room for any outstanding source.
- On a D beat (tl_d_valid_i) where slot[source] is busy and not done:
  - Store data and error = denied | corrupt | (d_opcode != expected).
  - Set done; the slot's data is captured at that edge.
- On a D beat for a free slot, an already-done slot, or a source >= MAX_OUTSTANDING: the beat is dropped and unexpected_d_o is set (sticky until reset).
- Response path:
  - resp_valid_o = done[retire], driven combinationally from table flops.
  - resp_rdata_o returns stored data for reads and 0 for writes.
  - On resp_valid_o & resp_ready_i the slot is freed (busy=0, done=0) and retire increments.
  - Minimum D-to-resp latency is one cycle.
- Simultaneous accept and retire in one cycle: count is unchanged. A slot freed by retire is reallocatable on the following cycle, not the same cycle.
- Simultaneous D beat and accept to different slots are both handled in the same cycle.
- When count == MAX_OUTSTANDING, req_ready_o=0 until a retire occurs.
- Pointer wrap from MAX_OUTSTANDING-1 to 0 is seamless.
- Reset asserted mid-transaction: all in-flight state is discarded. A late D beat after reset is flagged through unexpected_d_o.

Decomposition:
- Shared package tl_ul_pkg holds:
  - A opcode constants: Get=4, PutFullData=0, PutPartialData=1.
  - D opcode constants: AccessAck=0, AccessAckData=1.
  - TL_WORD_SIZE=2.
  - Slot struct typedef {busy, done, expect_data, error, data[31:0]}.
- One sub-module, tl_source_table:
  - Inputs: alloc, D-capture and retire ports.
  - Outputs: count, head-done, head-data, head-error and an unexpected pulse.
- The top level holds the A-channel register stage and the opcode mapping.

Test Plan:
- Read, slave answers AccessAckData data=32'hDEADBEEF after 3 cycles -> A beat shows Get, source 0, mask F, size 2; resp_rdata=32'hDEADBEEF, resp_error=0.
- Write mask 4'h3 data=32'h12345678 -> A beat shows PutPartialData, mask 3; AccessAck returned -> resp_valid with rdata=0, error=0.
- Four reads issued back to back, slave answers sources 3,1,0,2 with data=source*16 -> host responses appear in order with data 0,16,32,48. During the full period, req_ready_o=0 for a fifth request.
- tl_a_ready_i held low for 5 cycles -> A payload stays stable and no further request is accepted. Release -> the transfer completes.
- Write answered with denied=1, and a read answered with AccessAck (opcode mismatch) -> resp_error=1 for both.
- D beat with source 2 while idle -> dropped and unexpected_d_o=1. Reset asserted with 2 requests outstanding -> all outputs return to reset values immediately.
